// File: rtl/spi_slave.sv
// SPI slave for modes 0-3: synchronises the pins into clk, samples/shifts on the
// mode-selected s_clk edges, strobes each received byte and reloads the transmit byte.
module spi_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs_n,
  input  logic             s_clk,
  input  logic             mosi,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] slave_in,
  output logic             miso,
  output logic [WIDTH-1:0] slave_out,
  output logic             rx_valid,
  output logic             tx_load,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, csn_sync;
  logic                   sclk_prev, csn_prev;
  logic                   sclk_s, mosi_s, csn_s;
  logic                   cpol_q, cpha_q;
  logic [WIDTH-1:0]       tx_sr, rx_sr;
  logic [CW-1:0]          bit_cnt, tx_idx;
  logic                   sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic                   sample_edge, shift_edge, cs_fall, cs_rise;
  logic                   mode_cpol, mode_cpha;
  logic                   do_load, do_sample, do_complete, do_shift, do_err, go_idle;

  // cs_n chain resets high so a released reset never looks like a frame start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      csn_sync  <= '1;
      sclk_prev <= 1'b0;
      csn_prev  <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], s_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], cs_n};
      sclk_prev <= sclk_s;
      csn_prev  <= csn_s;
    end
  end

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign csn_s       = csn_sync[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_prev;
  assign sclk_fall   = ~sclk_s & sclk_prev;
  assign cs_fall     = ~csn_s & csn_prev;
  assign cs_rise     = csn_s & ~csn_prev;
  assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;
  assign mode_cpol   = (mode == 3'd2) || (mode == 3'd3);
  assign mode_cpha   = (mode == 3'd1) || (mode == 3'd3);
  // In both phases bit_cnt equals the number of bits already sampled, so it
  // directly selects the next outgoing bit, MSB first.
  assign tx_idx      = CW'(WIDTH - 1) - bit_cnt;
  assign busy        = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    do_load     = 1'b0;
    do_sample   = 1'b0;
    do_complete = 1'b0;
    do_shift    = 1'b0;
    do_err      = 1'b0;
    go_idle     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = LOAD;
          do_load = 1'b1;
        end
      end
      LOAD: begin
        if (cs_rise) begin
          state_d = IDLE;
          go_idle = 1'b1;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        do_sample   = sample_edge;
        do_complete = sample_edge && (bit_cnt == CW'(WIDTH - 1));
        if (cs_rise) begin
          state_d = IDLE;
          go_idle = 1'b1;
          do_err  = !do_complete && ((bit_cnt != '0) || sample_edge);
        end else begin
          do_shift = shift_edge;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The frame-start actions fire on the edge entering LOAD so every output
  // moves together, SYNC_STAGES+1 edges after the pin change is captured.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      miso      <= 1'b0;
      slave_out <= '0;
      rx_valid  <= 1'b0;
      tx_load   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      tx_load   <= 1'b0;
      frame_err <= do_err;
      if (do_load) begin
        cpol_q  <= mode_cpol;
        cpha_q  <= mode_cpha;
        tx_sr   <= slave_in;
        tx_load <= 1'b1;
        bit_cnt <= '0;
        if (!mode_cpha) miso <= slave_in[WIDTH-1];
      end
      if (do_sample) begin
        rx_sr   <= {rx_sr[WIDTH-2:0], mosi_s};
        bit_cnt <= bit_cnt + CW'(1);
      end
      if (do_complete) begin
        slave_out <= {rx_sr[WIDTH-2:0], mosi_s};
        rx_valid  <= 1'b1;
        bit_cnt   <= '0;
        tx_sr     <= slave_in;
        tx_load   <= 1'b1;
      end
      if (do_shift) miso <= tx_sr[tx_idx];
      if (go_idle) begin
        bit_cnt <= '0;
        miso    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-level SPI master drives frames while a
// byte-level model predicts received bytes, strobes and the master's read-back.
module tb_spi_slave;

  localparam int HALF = 8;

  logic       clk, reset, cs_n, s_clk, mosi;
  logic [2:0] mode;
  logic [7:0] slave_in, slave_out;
  logic       miso, rx_valid, tx_load, frame_err, busy;

  logic [7:0] exp_q[$];
  logic [7:0] mosi_bytes[4];
  logic [7:0] sin_bytes[4];
  logic       rx_bits[32];
  logic [7:0] last_out;
  int         load_cnt, sin_base, rx_cnt, err_cnt, ld_idx;
  bit         err_allowed;
  int         n_tests, n_fail;

  spi_slave #(.SYNC_STAGES(2), .WIDTH(8)) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .s_clk(s_clk), .mosi(mosi),
    .mode(mode), .slave_in(slave_in), .miso(miso), .slave_out(slave_out),
    .rx_valid(rx_valid), .tx_load(tx_load), .frame_err(frame_err), .busy(busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The slave's data source: advances to the next table byte after each tx_load.
  assign ld_idx = load_cnt - sin_base;
  always_comb slave_in = (ld_idx >= 3) ? sin_bytes[3] : sin_bytes[ld_idx[1:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] master_byte(input int k);
    logic [7:0] v;
    v = 8'h00;
    for (int j = 0; j < 8; j++) v = {v[6:0], rx_bits[8*k+j]};
    return v;
  endfunction

  // scoreboard: per-cycle checks of strobes and slave_out against the model
  initial begin
    last_out = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("reset_outputs", {miso, slave_out, rx_valid, tx_load, frame_err, busy}, 32'h0);
        last_out = 8'h00;
      end else begin
        check("strobe_exclusive", {31'h0, rx_valid & frame_err}, 32'h0);
        if (rx_valid) begin
          if (rx_cnt < exp_q.size()) begin
            check("rx_byte", slave_out, exp_q[rx_cnt]);
            last_out = exp_q[rx_cnt];
          end else begin
            check("rx_unexpected", rx_cnt, exp_q.size());
          end
          rx_cnt++;
        end else begin
          check("slave_out_hold", slave_out, last_out);
        end
        if (frame_err) begin
          err_cnt++;
          check("err_allowed", {31'h0, err_allowed}, 32'h1);
        end
        if (tx_load) load_cnt++;
      end
    end
  end

  // driver: one SPI frame of nbits; md_mid>=0 rewrites mode after bit 3;
  // cs_last raises cs_n on the final sample edge (cpha=1 modes only)
  task automatic run_frame(input int md, input int nbits, input bit cs_last, input int md_mid);
    bit cpol, cpha;
    int full, err0;
    cpol = (md == 2) || (md == 3);
    cpha = (md == 1) || (md == 3);
    full = nbits / 8;
    mode = 3'(md);
    s_clk = cpol;
    wait_clks(6);
    for (int k = 0; k < full; k++) exp_q.push_back(mosi_bytes[k]);
    err_allowed = (nbits % 8) != 0;
    err0 = err_cnt;
    sin_base = load_cnt;
    mosi = mosi_bytes[0][7];
    cs_n = 1'b0;
    wait_clks(HALF);
    check("busy_mid", {31'h0, busy}, 32'h1);
    for (int i = 0; i < nbits; i++) begin
      if (md_mid >= 0 && i == 3) mode = 3'(md_mid);
      if (!cpha) begin
        rx_bits[i] = miso;
        s_clk = ~cpol;
        wait_clks(HALF);
        s_clk = cpol;
        if (i + 1 < nbits) mosi = mosi_bytes[(i+1)/8][7-((i+1)%8)];
        wait_clks(HALF);
      end else begin
        s_clk = ~cpol;
        mosi = mosi_bytes[i/8][7-(i%8)];
        wait_clks(HALF);
        rx_bits[i] = miso;
        s_clk = cpol;
        if (cs_last && i == nbits - 1) cs_n = 1'b1;
        else wait_clks(HALF);
      end
    end
    cs_n = 1'b1;
    wait_clks(8);
    check("rx_count", rx_cnt, exp_q.size());
    check("err_count", err_cnt - err0, {31'h0, (nbits % 8) != 0});
    check("tx_load_count", load_cnt - sin_base, full + 1);
    check("busy_idle", {31'h0, busy}, 32'h0);
    check("miso_idle", {31'h0, miso}, 32'h0);
    for (int k = 0; k < full; k++) check("master_rx", master_byte(k), sin_bytes[k]);
    err_allowed = 1'b0;
  endtask

  initial begin
    reset = 1'b0; cs_n = 1'b1; s_clk = 1'b0; mosi = 1'b0; mode = 3'd0;
    sin_bytes = '{8'h00, 8'h00, 8'h00, 8'h00};
    mosi_bytes = '{8'h00, 8'h00, 8'h00, 8'h00};
    wait_clks(4);
    reset = 1'b1;
    wait_clks(4);

    // T1: mode 0, 0xA5 in, 0x3C out
    mosi_bytes[0] = 8'hA5; sin_bytes[0] = 8'h3C;
    run_frame(0, 8, 1'b0, -1);
    check("t1_slave_out", slave_out, 8'hA5);
    check("t1_master", master_byte(0), 8'h3C);

    // T2: modes 1..3, 0x81 in, 0x7E out
    for (int m = 1; m <= 3; m++) begin
      mosi_bytes[0] = 8'h81; sin_bytes[0] = 8'h7E;
      run_frame(m, 8, 1'b0, -1);
      check("t2_slave_out", slave_out, 8'h81);
      check("t2_master", master_byte(0), 8'h7E);
    end

    // cs_n rise coincident with the final sample edge still completes the byte
    mosi_bytes[0] = 8'h96; mosi_bytes[1] = 8'h4B;
    sin_bytes[0] = 8'hD2; sin_bytes[1] = 8'h1F;
    run_frame(1, 16, 1'b1, -1);
    check("cs_last_slave_out", slave_out, 8'h4B);

    // cs_n pulse with no clocks: silent return to idle
    run_frame(0, 0, 1'b0, -1);

    // T3: three back-to-back bytes, slave_in changes between bytes
    mosi_bytes[0] = 8'h01; mosi_bytes[1] = 8'h02; mosi_bytes[2] = 8'h03;
    sin_bytes[0] = 8'h11; sin_bytes[1] = 8'h22; sin_bytes[2] = 8'h33; sin_bytes[3] = 8'h44;
    run_frame(0, 24, 1'b0, -1);
    check("t3_master_b1", master_byte(1), 8'h22);
    check("t3_master_b2", master_byte(2), 8'h33);

    // T4: partial frame of 5 bits
    mosi_bytes[0] = 8'hFF;
    run_frame(0, 5, 1'b0, -1);
    check("t4_slave_out_kept", slave_out, 8'h03);

    // T5: reset mid-byte, then a clean frame
    mode = 3'd0; s_clk = 1'b0; mosi = 1'b1; sin_base = load_cnt;
    cs_n = 1'b0;
    wait_clks(HALF);
    s_clk = 1'b1; wait_clks(HALF);
    s_clk = 1'b0; wait_clks(HALF);
    s_clk = 1'b1; wait_clks(2);
    reset = 1'b0;
    wait_clks(6);
    cs_n = 1'b1; s_clk = 1'b0; mosi = 1'b0;
    wait_clks(2);
    reset = 1'b1;
    wait_clks(8);
    check("t5_busy_after_reset", {31'h0, busy}, 32'h0);
    mosi_bytes[0] = 8'h5A; sin_bytes[0] = 8'hE1;
    run_frame(0, 8, 1'b0, -1);
    check("t5_slave_out", slave_out, 8'h5A);

    // T6: mode 5 behaves as mode 0; mid-frame mode change is ignored
    mosi_bytes[0] = 8'hC3; sin_bytes[0] = 8'hA6;
    run_frame(5, 8, 1'b0, -1);
    check("t6_slave_out", slave_out, 8'hC3);
    mosi_bytes[0] = 8'hE7; sin_bytes[0] = 8'h5C;
    run_frame(0, 8, 1'b0, 3);
    check("t6_mid_slave_out", slave_out, 8'hE7);
    check("t6_mid_master", master_byte(0), 8'h5C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
